// File: rtl/running_light_multi.sv
// N-LED running-light pattern engine: eight pattern modes, a runtime step-rate
// divider, pause, and a one-cycle strobe on every LED update.
module running_light_multi #(
    parameter int N_LED     = 26,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [2:0]           light_mode,
    input  logic [DIV_WIDTH-1:0] speed_div,
    input  logic                 pause,
    output logic [N_LED-1:0]     led,
    output logic                 step_tick
);

    // Wide enough for the longest period (bounce, 2*N_LED-2) and for the
    // value N_LED used as the bar-fill all-off frame.
    localparam int FW = $clog2(2 * N_LED);
    localparam logic [FW-1:0]        F_ONE   = FW'(1);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [2:0]           r_mode_q;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [FW-1:0]        r_f;
    logic [N_LED-1:0]     r_led;
    logic                 r_step_tick;

    logic                 w_step;
    logic [FW-1:0]        w_f_next;
    logic [N_LED-1:0]     w_frame;

    // Index of the final frame of each mode; f wraps from here back to 0.
    function automatic logic [FW-1:0] last_frame(input logic [2:0] m);
        case (m)
            3'd0, 3'd1: return FW'(N_LED - 1);
            3'd2:       return FW'(2 * N_LED - 3);
            3'd3:       return FW'(N_LED);
            3'd4:       return FW'((N_LED + 1) / 2);
            3'd5, 3'd6: return F_ONE;
            default:    return '0;
        endcase
    endfunction

    function automatic logic [N_LED-1:0] frame_leds(input logic [2:0] m, input int f);
        logic [N_LED-1:0] v;
        int               pos;
        v   = '0;
        pos = (f < N_LED) ? f : (2 * N_LED - 2 - f);
        for (int i = 0; i < N_LED; i++) begin
            case (m)
                3'd0:    v[i] = (i == f);
                3'd1:    v[i] = (i == N_LED - 1 - f);
                3'd2:    v[i] = (i == pos);
                3'd3:    v[i] = (f < N_LED) && (i <= f);
                // Lit span grows outward from the middle pair (or middle LED).
                3'd4:    v[i] = (f < (N_LED + 1) / 2) && (i >= (N_LED - 1) / 2 - f)
                                && (i <= N_LED / 2 + f);
                3'd5:    v[i] = (f == 0);
                3'd6:    v[i] = ((f == 0) == ((i % 2) == 0));
                default: v[i] = 1'b0;
            endcase
        end
        return v;
    endfunction

    assign w_step   = (r_cnt >= speed_div);
    assign w_f_next = (r_f == last_frame(r_mode_q)) ? '0 : (r_f + F_ONE);
    assign w_frame  = frame_leds(r_mode_q, int'(r_f));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_mode_q    <= light_mode;
            r_cnt       <= '0;
            r_f         <= '0;
            r_led       <= '0;
            r_step_tick <= 1'b0;
        end else if (light_mode != r_mode_q) begin
            r_mode_q    <= light_mode;
            r_cnt       <= '0;
            r_f         <= '0;
            r_led       <= '0;
            r_step_tick <= 1'b0;
        end else if (pause) begin
            r_step_tick <= 1'b0;
        end else if (w_step) begin
            r_cnt       <= '0;
            r_f         <= w_f_next;
            r_led       <= w_frame;
            r_step_tick <= 1'b1;
        end else begin
            r_cnt       <= r_cnt + CNT_ONE;
            r_step_tick <= 1'b0;
        end
    end

    assign led       = r_led;
    assign step_tick = r_step_tick;

endmodule

// File: tb/tb_running_light_multi.sv
// Directed bench for running_light_multi: 8-LED, 5-LED and 26-LED banks share
// one set of inputs; expected frames are hand-written tables.
module tb_running_light_multi;

    logic        Clk;
    logic        Rst;
    logic [2:0]  light_mode;
    logic [23:0] speed_div;
    logic        pause;
    logic [7:0]  led8;
    logic [4:0]  led5;
    logic [25:0] led26;
    logic        tick8, tick5, tick26;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] bounce8 [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    logic [4:0] bounce5 [8]  = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02};
    logic [7:0] bar8 [9]     = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [4:0] bar5 [6]     = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F, 5'h00};
    logic [7:0] center8 [5]  = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h00};
    logic [4:0] center5 [4]  = '{5'h04, 5'h0E, 5'h1F, 5'h00};

    running_light_multi #(.N_LED(8), .DIV_WIDTH(24)) dut8 (
        .Clk(Clk), .Rst(Rst), .light_mode(light_mode), .speed_div(speed_div),
        .pause(pause), .led(led8), .step_tick(tick8));

    running_light_multi #(.N_LED(5), .DIV_WIDTH(24)) dut5 (
        .Clk(Clk), .Rst(Rst), .light_mode(light_mode), .speed_div(speed_div),
        .pause(pause), .led(led5), .step_tick(tick5));

    running_light_multi #(.N_LED(26), .DIV_WIDTH(24)) dut26 (
        .Clk(Clk), .Rst(Rst), .light_mode(light_mode), .speed_div(speed_div),
        .pause(pause), .led(led26), .step_tick(tick26));

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic step_chk8(input string tag, input logic [7:0] e_led, input logic e_tick);
        step();
        check({tag, "_led"}, 64'(led8), 64'(e_led));
        check({tag, "_tick"}, 64'(tick8), 64'(e_tick));
    endtask

    // Expected 26-LED frame k after a mode change, written per mode.
    function automatic logic [25:0] exp26(input int m, input int k);
        logic [63:0] v;
        int p;
        v = 64'd0;
        case (m)
            0: v = 64'd1 << (k % 26);
            1: v = 64'd1 << (25 - (k % 26));
            2: begin
                p = k % 50;
                v = 64'd1 << ((p < 26) ? p : (50 - p));
            end
            3: begin
                p = k % 27;
                if (p < 26) v = (64'd1 << (p + 1)) - 64'd1;
            end
            4: begin
                p = k % 14;
                if (p < 13) v = ((64'd1 << (2 * p + 2)) - 64'd1) << (12 - p);
            end
            5: v = ((k % 2) == 0) ? 64'h3FF_FFFF : 64'd0;
            6: v = ((k % 2) == 0) ? 64'h155_5555 : 64'h2AA_AAAA;
            default: v = 64'd0;
        endcase
        return v[25:0];
    endfunction

    initial begin
        logic [7:0] e8;
        Rst = 1'b0; light_mode = 3'd0; speed_div = 24'd0; pause = 1'b0;

        // reset state
        step_chk8("rst", 8'h00, 1'b0);
        check("rst_led26", 64'(led26), 64'd0);
        check("rst_led5", 64'(led5), 64'd0);

        // mode 0, step every clock, wraps 80 -> 01
        Rst = 1'b1;
        for (int k = 0; k < 13; k++) begin
            e8 = 8'h01 << (k % 8);
            step_chk8("m0_shift", e8, 1'b1);
        end

        // reset mid-pattern at led=10
        Rst = 1'b0;
        step_chk8("rst_mid", 8'h00, 1'b0);
        step();
        step_chk8("rst_hold", 8'h00, 1'b0);
        Rst = 1'b1;
        step_chk8("rst_rel", 8'h01, 1'b1);
        check("rst_rel_led5", 64'(led5), 64'h01);
        check("rst_rel_led26", 64'(led26), 64'h1);

        // speed_div=3: one step per 4 clocks
        speed_div = 24'd3;
        for (int r = 0; r < 2; r++) begin
            e8 = 8'h01 << r;
            for (int c = 0; c < 3; c++) step_chk8("div3_wait", e8, 1'b0);
            e8 = 8'h02 << r;
            step_chk8("div3_step", e8, 1'b1);
        end

        // mode 2 bounce
        speed_div = 24'd0;
        light_mode = 3'd2;
        step_chk8("m2_chg", 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step_chk8("m2_bounce", bounce8[k % 14], 1'b1);
            check("m2_bounce5", 64'(led5), 64'(bounce5[k % 8]));
        end

        // mode 3 bar fill
        light_mode = 3'd3;
        step_chk8("m3_chg", 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step_chk8("m3_bar", bar8[k % 9], 1'b1);
            check("m3_bar5", 64'(led5), 64'(bar5[k % 6]));
        end

        // mode 4 center-out (even and odd widths)
        light_mode = 3'd4;
        step_chk8("m4_chg", 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step_chk8("m4_center", center8[k % 5], 1'b1);
            check("m4_center5", 64'(led5), 64'(center5[k % 4]));
        end

        // pause at led=04 holds; release continues with 08
        light_mode = 3'd0;
        step_chk8("m0_chg", 8'h00, 1'b0);
        step_chk8("m0_a", 8'h01, 1'b1);
        step_chk8("m0_b", 8'h02, 1'b1);
        step_chk8("m0_c", 8'h04, 1'b1);
        pause = 1'b1;
        for (int c = 0; c < 10; c++) step_chk8("pause_hold", 8'h04, 1'b0);
        pause = 1'b0;
        step_chk8("pause_rel", 8'h08, 1'b1);

        // pause raised with a mode change: mode change wins, then stays paused
        pause = 1'b1;
        light_mode = 3'd6;
        step_chk8("pause_mode", 8'h00, 1'b0);
        step_chk8("pause_m6", 8'h00, 1'b0);
        step_chk8("pause_m6b", 8'h00, 1'b0);
        pause = 1'b0;
        step_chk8("m6_a", 8'h55, 1'b1);
        step_chk8("m6_b", 8'hAA, 1'b1);
        step_chk8("m6_c", 8'h55, 1'b1);

        // speed_div lowered below the running count
        light_mode = 3'd0;
        speed_div = 24'd100;
        step_chk8("div_chg", 8'h00, 1'b0);
        for (int c = 0; c < 50; c++) step();
        check("div100_led", 64'(led8), 64'h00);
        check("div100_tick", 64'(tick8), 64'd0);
        speed_div = 24'd2;
        step_chk8("div_lower", 8'h01, 1'b1);
        step_chk8("div2_w1", 8'h01, 1'b0);
        step_chk8("div2_w2", 8'h01, 1'b0);
        step_chk8("div2_step", 8'h02, 1'b1);

        // mode 0 -> 5 mid-run
        speed_div = 24'd0;
        light_mode = 3'd5;
        step_chk8("m5_chg", 8'h00, 1'b0);
        step_chk8("m5_a", 8'hFF, 1'b1);
        step_chk8("m5_b", 8'h00, 1'b1);
        step_chk8("m5_c", 8'hFF, 1'b1);

        // mode 7: dark, strobe still pulses
        light_mode = 3'd7;
        step_chk8("m7_chg", 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) step_chk8("m7_off", 8'h00, 1'b1);

        // 26-LED bank through all modes
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        for (int m = 0; m < 8; m++) begin
            light_mode = 3'(m);
            step();
            check("b26_chg", 64'(led26), 64'd0);
            for (int k = 0; k < 30; k++) begin
                step();
                check($sformatf("b26_m%0d_f%0d", m, k), 64'(led26), 64'(exp26(m, k)));
                check("b26_tick", 64'(tick26), 64'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
